// File: rtl/fetch_queue.sv
// Instruction-fetch unit with a DEPTH-entry prefetch queue, credit-based request issue and redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`else
  output logic [XLEN-1:0] inst_pc
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] respPc_q, respPc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [XLEN-1:0] pcMem_q   [DEPTH];
  logic [XLEN-1:0] dataMem_q [DEPTH];

  logic            credit;
  logic            reqFire;
  logic            respDrop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirectAligned;

  // Every word in the queue or in flight holds a slot, so responses can never overflow the queue.
  assign credit          = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);
  assign mem_req_valid   = rst && credit && !redirect;
  assign mem_req_addr    = fetchPc_q;
  assign reqFire         = mem_req_valid && mem_req_ready;
  assign respDrop        = mem_resp_valid && (redirect || (discard_q != '0));
  assign push            = mem_resp_valid && !respDrop;
  assign inst_valid      = (count_q != '0) && !redirect;
  assign pop             = inst_valid && inst_ready;
  assign inst            = dataMem_q[head_q];
  assign inst_pc         = pcMem_q[head_q];
  assign redirectAligned = redirect_pc & ~XLEN'(3);

  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    count_d       = count_q;
    discard_d     = discard_q;
    head_d        = head_q;
    tail_d        = tail_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(mem_resp_valid);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetchPc_d = redirectAligned;
      respPc_d  = redirectAligned;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      discard_d = outstanding_q - CW'(mem_resp_valid);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + XLEN'(4);
      if (mem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        respPc_d = respPc_q + XLEN'(4);
        tail_d   = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[tail_q]   <= respPc_q;
      dataMem_q[tail_q] <= mem_resp_data;
    end
  end

  noPushWhenFull: assert property (@(posedge clk) disable iff (!rst) push |-> (count_q != CW'(DEPTH)));

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q, perfFetched_d;
  logic [31:0] perfFlushed_q, perfFlushed_d;

  // Flushed work covers dropped responses plus whatever the redirect throws out of the queue.
  always_comb begin
    perfFetched_d = perfFetched_q + 32'(pop);
    perfFlushed_d = perfFlushed_q + 32'(respDrop) + (redirect ? 32'(count_q) : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfFetched_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      perfFetched_q <= perfFetched_d;
      perfFlushed_q <= perfFlushed_d;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_flushed = perfFlushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with configurable latency, a pop monitor,
// and hand-computed expectations for streaming, stall, redirect and randomised-latency traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word stored at each address, easy to work out by hand.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memEntry_t;

  memEntry_t memQ[$];
  int memCycle    = 0;
  int memLatMin   = 1;
  int memLatMax   = 1;
  int maxInFlight = 0;

  // In-order pipelined memory: handshakes sampled mid-cycle, responses driven just after the edge.
  always begin
    @(negedge clk);
    if (!rst) begin
      memQ.delete();
    end else begin
      if (mem_resp_valid && memQ.size() > 0) void'(memQ.pop_front());
      if (mem_req_valid && mem_req_ready) begin
        memQ.push_back('{addr: mem_req_addr, due: memCycle + int'($urandom_range(memLatMax, memLatMin))});
        if (memQ.size() > maxInFlight) maxInFlight = memQ.size();
      end
    end
    memCycle++;
    @(posedge clk);
    #1;
    if (rst && memQ.size() > 0 && memQ[0].due <= memCycle) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = memWord(memQ[0].addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  end

  logic [31:0] popPc[$];
  logic [31:0] popData[$];
  int reqCount = 0;

  // Records every instruction handed to decode and every accepted request.
  always @(negedge clk) begin
    if (rst) begin
      if (inst_valid && inst_ready) begin
        popPc.push_back(inst_pc);
        popData.push_back(inst);
      end
      if (mem_req_valid && mem_req_ready) reqCount++;
    end
  end

  task automatic applyStimulus(input logic rstN, input logic rdr, input logic [31:0] rpc,
                               input logic rdy, input logic mrdy);
    @(posedge clk);
    #1;
    rst           = rstN;
    redirect      = rdr;
    redirect_pc   = rpc;
    inst_ready    = rdy;
    mem_req_ready = mrdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int base2;
    int reqBase;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset mem_req_addr", mem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("reset perf_fetched", perf_fetched, 32'd0);
    checkOutput("reset perf_flushed", perf_flushed, 32'd0);
`endif

    // Streaming with a 1-cycle memory
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stream req_valid c0", 32'(mem_req_valid), 32'd1);
    checkOutput("stream addr c0", mem_req_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stream addr c1", mem_req_addr, 32'h4);
    checkOutput("stream inst_valid c1", 32'(inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stream addr c2", mem_req_addr, 32'h8);
    checkOutput("stream inst_valid c2", 32'(inst_valid), 32'd1);
    checkOutput("stream inst_pc c2", inst_pc, 32'h0);
    checkOutput("stream inst c2", inst, 32'hBEEF_0000);
    repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream pop pc", popPc[i], 32'(4 * i));
      checkOutput("stream pop data", popData[i], memWord(32'(4 * i)));
    end

    // Decode stall fills the queue and stops requests
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    base    = popPc.size();
    reqBase = reqCount;
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stall req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("stall inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("stall head pc", inst_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stall request count", 32'(reqCount - reqBase), 32'd4);
    checkOutput("stall no pops", 32'(popPc.size() - base), 32'd0);
    repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall release pc", popPc[base + i], 32'(4 * i));
      checkOutput("stall release data", popData[base + i], memWord(32'(4 * i)));
    end

    // Redirect with three requests outstanding, 3-cycle memory
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    memLatMin = 3;
    memLatMax = 3;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    base = popPc.size();
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("redirect cycle req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("redirect cycle inst_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("redirect new req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("redirect new addr", mem_req_addr, 32'h100);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("redirect first pc", popPc[base], 32'h100);
    checkOutput("redirect first data", popData[base], memWord(32'h100));
    checkOutput("redirect second pc", popPc[base + 1], 32'h104);

    // Unaligned redirect target, then two back-to-back redirects
    memLatMin = 1;
    memLatMax = 1;
    applyStimulus(1'b1, 1'b1, 32'h203, 1'b1, 1'b1);
    base = popPc.size();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("unaligned addr", mem_req_addr, 32'h200);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("unaligned first pc", popPc[base], 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    base2 = popPc.size();
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("double redirect addr", mem_req_addr, 32'h80);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("double redirect first pc", popPc[base2], 32'h80);
    checkOutput("double redirect first data", popData[base2], memWord(32'h80));
    checkOutput("double redirect second pc", popPc[base2 + 1], 32'h84);

    // Toggling request ready with random 1-5 cycle latency
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    memLatMin = 1;
    memLatMax = 5;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    base = popPc.size();
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, ($urandom_range(0, 3) != 0), (c % 2 == 0));
    end
    n = popPc.size() - base;
    checkOutput("random enough pops", 32'(n >= 40), 32'd1);
    for (int i = 0; i < n; i++) begin
      checkOutput("random pop pc", popPc[base + i], 32'(4 * i));
      checkOutput("random pop data", popData[base + i], memWord(32'(4 * i)));
    end
    checkOutput("max outstanding within depth", 32'(maxInFlight <= DEPTH), 32'd1);

`ifdef FETCH_PERF_EN
    // Ten pops, then a redirect flushing two queued words and one in-flight word
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    memLatMin = 1;
    memLatMax = 1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    base = popPc.size();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      rst           = 1'b1;
      mem_req_ready = 1'b1;
      inst_ready    = (popPc.size() - base) < 10;
      if (!inst_ready) break;
    end
    checkOutput("perf reached ten pops", 32'(inst_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("perf_fetched", perf_fetched, 32'd10);
    checkOutput("perf_flushed", perf_flushed, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
